switch_input_pio: RTL



---
 rtl/switch_input_pio.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/switch_input_pio.sv
// switch_input_pio: Avalon-MM slave input port for board switches.
// Syncs, debounces and edge-captures switch_in; raises a maskable irq.
//
// Parameters:
//   WIDTH           number of switch inputs (1..32)
//   DEBOUNCE_CYCLES stable cycles before a debounced bit changes
//   SYNC_STAGES     synchronizer depth (2..4)
//   EDGE_TYPE       0 rising, 1 falling, 2 both
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   avs_address/read/write/writedata/readdata  Avalon-MM slave
//                       (read latency 1, no waitrequest)
//   irq                 registered level interrupt, active high
//   switch_in           raw asynchronous switch pins
//
// Register map (word address):
//   0 DATA (RO)  1 MASK (RW)  2 EDGE (W1C)  3 RAW (RO)
//
// Optional feature macro: SWITCH_PIO_IRQ_EN
//   defined   -> MASK/EDGE storage and irq are built
//   undefined -> addresses 1/2 read 0, writes ignored, irq = 0

module switch_input_pio #(
   parameter int WIDTH           = 1,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SYNC_STAGES     = 2,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic             irq,
   input  logic [WIDTH-1:0] switch_in
);

   localparam logic [23:0] CNT_MAX = 24'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] load;
   logic [WIDTH-1:0] evt;
   logic [23:0]      cnt [WIDTH];
   logic [31:0]      mask_rd;
   logic [31:0]      edge_rd;
   logic [31:0]      rd_mux;

   // ------------------------------------------------------------
   // Synchronizer
   // ------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++)
            sync_q[s] <= '0;
      end else begin
         sync_q[0] <= switch_in;
         for (int s = 1; s < SYNC_STAGES; s++)
            sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------
   // Debounce: a bit must differ for DEBOUNCE_CYCLES consecutive
   // cycles before stable follows it. load marks that cycle.
   // ------------------------------------------------------------
   always_comb begin
      load = '0;
      for (int i = 0; i < WIDTH; i++)
         load[i] = (sync[i] != stable[i]) && (cnt[i] == CNT_MAX);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable <= '0;
         for (int i = 0; i < WIDTH; i++)
            cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (load[i]) begin
               cnt[i]    <= '0;
               stable[i] <= sync[i];
            end else begin
               cnt[i] <= cnt[i] + 24'd1;
            end
         end
      end
   end

   // ------------------------------------------------------------
   // Edge qualification: evt fires in the cycle stable is loaded,
   // so capture sets on the same edge that stable changes.
   // ------------------------------------------------------------
   always_comb begin
      if (EDGE_TYPE == 0)
         evt = load & sync;
      else if (EDGE_TYPE == 1)
         evt = load & ~sync;
      else
         evt = load;
   end

`ifdef SWITCH_PIO_IRQ_EN
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] capture;
   logic [WIDTH-1:0] clr;
   logic             irq_q;
   logic             wr_mask;
   logic             wr_edge;
   logic             unused_ok;

   assign wr_mask = avs_write && (avs_address == 2'd1);
   assign wr_edge = avs_write && (avs_address == 2'd2);
   assign clr     = wr_edge ? avs_writedata[WIDTH-1:0] : '0;

   // Set has priority over clear so no edge is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask    <= '0;
         capture <= '0;
         irq_q   <= 1'b0;
      end else begin
         if (wr_mask)
            mask <= avs_writedata[WIDTH-1:0];
         capture <= (capture & ~clr) | evt;
         irq_q   <= |(capture & mask);
      end
   end

   assign irq       = irq_q;
   assign mask_rd   = 32'(mask);
   assign edge_rd   = 32'(capture);
   assign unused_ok = ^avs_writedata;
`else
   logic unused_ok;

   assign irq       = 1'b0;
   assign mask_rd   = '0;
   assign edge_rd   = '0;
   assign unused_ok = ^{avs_writedata, avs_write, evt};
`endif

   // ------------------------------------------------------------
   // Read path: registered, so a same-cycle write is not visible.
   // ------------------------------------------------------------
   always_comb begin
      rd_mux = '0;
      unique case (avs_address)
         2'd0: rd_mux = 32'(stable);
         2'd1: rd_mux = mask_rd;
         2'd2: rd_mux = edge_rd;
         2'd3: rd_mux = 32'(sync);
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         avs_readdata <= '0;
      else if (avs_read)
         avs_readdata <= rd_mux;
   end

endmodule
